sram_ctrl: RTL and testbench

- Downstream neighbour of the MEM stage; sits between MEM and the board's 32-bit asynchronous SRAM.
- Consumes MEM's physical access request: ce, we, addr, sel and write data.
- Runs a multi-cycle SRAM read or write with configurable wait states, holding the pipeline via stall_req_o.
- Returns the full 32-bit read word to MEM, which performs byte/half lane extraction itself.

---
 rtl/sram_ctrl_pkg.sv | 18 +
 rtl/sram_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the MEM-side asynchronous SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        SRAM_IDLE  = 2'd0,
        SRAM_READ  = 2'd1,
        SRAM_WRITE = 2'd2,
        SRAM_DONE  = 2'd3
    } sram_state_t;

    // Wait counter load value: a state lasting N cycles counts N-1 down to 0.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Multi-cycle read/write controller for a 32-bit asynchronous SRAM, stalling MEM
// until the access completes; strobes are registered from the next state.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_AW    = 20,
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [3:0]         sel_i,
    input  logic [31:0]        data_i,
    input  logic               flush_i,
    output logic [31:0]        data_o,
    output logic               stall_req_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_dq_o,
    output logic               sram_dq_oe_o,
    input  logic [31:0]        sram_dq_i,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [3:0]         sram_be_n_o
);

    sram_state_t      state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [3:0]       be_q;
    logic             accept_c;
    logic             capture_c;
    logic             active_c;
    logic             unused_addr_c;

    // Byte offset and upper address bits are not part of the SRAM word address.
    assign unused_addr_c = ^{addr_i[31:SRAM_AW+2], addr_i[1:0]};

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        accept_c   = 1'b0;
        capture_c  = 1'b0;
        case (state)
            SRAM_IDLE: begin
                if (ce_i && !flush_i) begin
                    accept_c   = 1'b1;
                    next_state = we_i ? SRAM_WRITE : SRAM_READ;
                    next_cnt   = we_i ? wait_load(WRITE_WAIT) : wait_load(READ_WAIT);
                end
            end
            SRAM_READ: begin
                if (flush_i) begin
                    next_state = SRAM_IDLE;
                    next_cnt   = '0;
                end else if (cnt == '0) begin
                    capture_c  = 1'b1;
                    next_state = SRAM_DONE;
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            // A started write always finishes so the WE pulse is never truncated.
            SRAM_WRITE: begin
                if (cnt == '0) begin
                    next_state = SRAM_DONE;
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            SRAM_DONE: begin
                next_state = SRAM_IDLE;
            end
            default: begin
                next_state = SRAM_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    assign active_c = (next_state == SRAM_READ) || (next_state == SRAM_WRITE);

    assign stall_req_o = !flush_i &&
                         (((state == SRAM_IDLE) && ce_i) ||
                          (state == SRAM_READ) || (state == SRAM_WRITE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SRAM_IDLE;
            cnt          <= '0;
            be_q         <= 4'hF;
            data_o       <= '0;
            sram_addr_o  <= '0;
            sram_dq_o    <= '0;
            sram_dq_oe_o <= 1'b0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            sram_be_n_o  <= 4'hF;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (accept_c) begin
                sram_addr_o <= addr_i[SRAM_AW+1:2];
                be_q        <= ~sel_i;
                sram_dq_o   <= data_i;
            end
            if (capture_c) begin
                data_o <= sram_dq_i;
            end
            sram_ce_n_o  <= !active_c;
            sram_oe_n_o  <= (next_state != SRAM_READ);
            sram_we_n_o  <= !((next_state == SRAM_WRITE) && (next_cnt != '0));
            sram_dq_oe_o <= (next_state == SRAM_WRITE);
            sram_be_n_o  <= active_c ? (accept_c ? ~sel_i : be_q) : 4'hF;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: directed accesses against a small SRAM model.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i, we_i, flush_i;
    logic [31:0] addr_i, data_i;
    logic [3:0]  sel_i;
    logic [31:0] data_o;
    logic        stall_req_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    logic [3:0]  sram_be_n_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    typedef struct {
        logic [31:0] data;
        int          n_ce, n_oe, n_we, n_dq;
        logic [19:0] addr;
        logic [3:0]  be;
        bit          chk_mem;
        int          idx;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];

    sram_ctrl #(.SRAM_AW(20), .READ_WAIT(2), .WRITE_WAIT(3)) dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
        .sel_i(sel_i), .data_i(data_i), .flush_i(flush_i), .data_o(data_o),
        .stall_req_o(stall_req_o), .sram_addr_o(sram_addr_o), .sram_dq_o(sram_dq_o),
        .sram_dq_oe_o(sram_dq_oe_o), .sram_dq_i(sram_dq_i), .sram_ce_n_o(sram_ce_n_o),
        .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: reads while CE/OE low, writes enabled lanes while WE low.
    assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (!sram_ce_n_o && !sram_we_n_o && sram_dq_oe_o) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n_o[b]) mem[sram_addr_o[7:0]][b*8 +: 8] <= sram_dq_o[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: accumulate strobe activity while CE is low, check on the cycle it releases.
    int          m_ce = 0, m_oe = 0, m_we = 0, m_dq = 0, m_ovl = 0;
    logic [19:0] m_addr;
    logic [3:0]  m_be;
    bit          prev_active = 0;

    always @(negedge clk) begin
        if (!sram_ce_n_o) begin
            if (m_ce == 0) begin
                m_addr = sram_addr_o;
                m_be   = sram_be_n_o;
            end
            m_ce++;
            if (!sram_oe_n_o) m_oe++;
            if (!sram_we_n_o) m_we++;
            if (sram_dq_oe_o) m_dq++;
            if (sram_dq_oe_o && !sram_oe_n_o) m_ovl++;
        end else if (prev_active) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_data_o", data_o, e.data);
                chk("mon_stall_end", 32'(stall_req_o), 32'd0);
                chk("mon_ce_cycles", 32'(m_ce), 32'(e.n_ce));
                chk("mon_oe_cycles", 32'(m_oe), 32'(e.n_oe));
                chk("mon_we_cycles", 32'(m_we), 32'(e.n_we));
                chk("mon_dq_oe_cycles", 32'(m_dq), 32'(e.n_dq));
                chk("mon_overlap", 32'(m_ovl), 32'd0);
                chk("mon_addr", 32'(m_addr), 32'(e.addr));
                chk("mon_be_n", 32'(m_be), 32'(e.be));
                if (e.chk_mem) chk("mon_mem_word", mem[e.idx], e.word);
            end
            m_ce = 0; m_oe = 0; m_we = 0; m_dq = 0; m_ovl = 0;
        end
        prev_active = !sram_ce_n_o;
    end

    function automatic exp_t mk(input logic [31:0] data, input int nce, input int noe,
                                input int nwe, input int ndq, input logic [19:0] addr,
                                input logic [3:0] be, input bit cm, input int idx,
                                input logic [31:0] word);
        exp_t e;
        e.data = data; e.n_ce = nce; e.n_oe = noe; e.n_we = nwe; e.n_dq = ndq;
        e.addr = addr; e.be = be; e.chk_mem = cm; e.idx = idx; e.word = word;
        return e;
    endfunction

    // Issue one request from IDLE (posedge+1), count stall cycles until DONE.
    task automatic access(input string name, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] data,
                          input int exp_stall, input bit hold);
        int n;
        ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = data;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall_req_o) break;
            n++;
        end
        chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        @(posedge clk); #1;
        if (!hold) ce_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h41] = 32'hDEADBEEF;
        mem[8'h80] = 32'h11223344;
        mem[8'h82] = 32'h55667788;

        rst = 1'b1; ce_i = 0; we_i = 0; flush_i = 0; addr_i = 0; sel_i = 0; data_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_stall", 32'(stall_req_o), 32'd0);
        chk("rst_addr", 32'(sram_addr_o), 32'h0);
        chk("rst_dq", sram_dq_o, 32'h0);
        chk("rst_strobes", {28'h0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o}, 32'hE);
        chk("rst_be_n", 32'(sram_be_n_o), 32'hF);
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back read then write with ce_i held across DONE.
        sb.push_back(mk(32'h55667788, 2, 2, 0, 0, 20'h00082, 4'h0, 0, 0, 0));
        access("b2b_rd", 1'b0, 32'h0000_0208, 4'hF, 32'h0, 3, 1);
        sb.push_back(mk(32'h55667788, 3, 0, 2, 3, 20'h00083, 4'b1100, 1, 8'h83, 32'h0000F00D));
        access("b2b_wr", 1'b1, 32'h0000_020C, 4'b0011, 32'hCAFEF00D, 4, 0);

        sb.push_back(mk(32'hDEADBEEF, 2, 2, 0, 0, 20'h00041, 4'h0, 0, 0, 0));
        access("rd", 1'b0, 32'h0000_0104, 4'hF, 32'h0, 3, 0);

        sb.push_back(mk(32'hDEADBEEF, 3, 0, 2, 3, 20'h00080, 4'b0111, 1, 8'h80, 32'hAA223344));
        access("wr_byte", 1'b1, 32'h0000_0203, 4'b1000, 32'hAAAAAAAA, 4, 0);

        // No lanes selected: the read still runs with all byte enables inactive.
        sb.push_back(mk(32'hDEADBEEF, 2, 2, 0, 0, 20'h00041, 4'hF, 0, 0, 0));
        access("rd_nosel", 1'b0, 32'h0000_0104, 4'h0, 32'h0, 3, 0);

        // Flush on the first READ cycle aborts without capturing.
        mem[8'h41] = 32'h0BADF00D;
        sb.push_back(mk(32'hDEADBEEF, 1, 1, 0, 0, 20'h00041, 4'h0, 0, 0, 0));
        ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0104; sel_i = 4'hF;
        @(posedge clk); #1;
        flush_i = 1'b1; ce_i = 1'b0;
        @(negedge clk);
        chk("flush_rd_stall", 32'(stall_req_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_rd_oe_n", 32'(sram_oe_n_o), 32'd1);
        chk("flush_rd_data_o", data_o, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Request with flush in IDLE is ignored.
        ce_i = 1'b1; flush_i = 1'b1; we_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_flush_ce_n", 32'(sram_ce_n_o), 32'd1);
            chk("idle_flush_stall", 32'(stall_req_o), 32'd0);
        end
        @(posedge clk); #1;
        ce_i = 1'b0; flush_i = 1'b0;
        @(posedge clk); #1;

        // Reset while WE is low abandons the write.
        sb.push_back(mk(32'h0, 1, 0, 1, 1, 20'h000C0, 4'h0, 0, 0, 0));
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0300; sel_i = 4'hF; data_i = 32'h12345678;
        @(posedge clk); #1;
        ce_i = 1'b0;
        @(negedge clk);
        chk("rst_wr_we_low", 32'(sram_we_n_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_we_n", 32'(sram_we_n_o), 32'd1);
        chk("rst_wr_ce_n", 32'(sram_ce_n_o), 32'd1);
        chk("rst_wr_dq_oe", 32'(sram_dq_oe_o), 32'd0);
        chk("rst_wr_stall", 32'(stall_req_o), 32'd0);
        chk("rst_wr_data_o", data_o, 32'h0);
        rst = 1'b0;

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
